// File: rtl/mat_vec_sequencer_pkg.sv
// Shared types and helpers for the matrix-by-vector sequencer.
package mat_vec_pkg;

  localparam int unsigned NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  typedef logic [1:0] row_t;

  typedef struct packed {
    logic valid;
    row_t row;
  } tag_t;

  // Constant ONE: 1 for integer data, 1.0 in Q(W/2).(W/2) for fixed point.
  function automatic logic [63:0] one_value(input int unsigned width, input bit fixed_point);
    if (fixed_point) return 64'(64'd1 << (width / 2));
    return 64'd1;
  endfunction

endpackage

// File: rtl/mat_vec_sequencer_if.sv
// Vertex in/out, matrix write and dot-stage operand bus of the sequencer.
interface mat_vec_sequencer_if
  import mat_vec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned VEC_W = 4 * WIDTH;

  logic             mat_wr_en;
  row_t             mat_wr_row;
  logic [VEC_W-1:0] mat_wr_data;
  logic             vin_valid;
  logic             vin_ready;
  logic [VEC_W-1:0] vin_data;
  logic [VEC_W-1:0] dp_x_out;
  logic [VEC_W-1:0] dp_y_out;
  logic             dp_valid_out;
  logic [WIDTH-1:0] dp_res_in;
  logic             vout_valid;
  logic             vout_ready;
  logic [VEC_W-1:0] vout_data;
  logic             busy;

  modport slave (
    input  mat_wr_en, mat_wr_row, mat_wr_data, vin_valid, vin_data, dp_res_in, vout_ready,
    output vin_ready, dp_x_out, dp_y_out, dp_valid_out, vout_valid, vout_data, busy
  );

  modport master (
    output mat_wr_en, mat_wr_row, mat_wr_data, vin_valid, vin_data, dp_res_in, vout_ready,
    input  vin_ready, dp_x_out, dp_y_out, dp_valid_out, vout_valid, vout_data, busy
  );

endinterface

// File: rtl/mat_vec_sequencer_tag_pipe.sv
// Latency-matched {valid,row} shift register tracking operands inside the dot stage.
module issue_tag_pipe
  import mat_vec_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [DEPTH];

  // Shift one stage per cycle; reset discards every tag in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mat_vec_sequencer.sv
// 4x4 matrix by 4-vector sequencer feeding an external dot-product stage.
// Optional build macro MATVEC_AFFINE_EN: skip row 3 and force output w to ONE.
module mat_vec_sequencer
  import mat_vec_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter bit          FIXED_POINT = 1'b0,
  parameter int unsigned DOT_LATENCY = 3
) (
  input logic               clk_in,
  input logic               rst_n_in,
  mat_vec_sequencer_if.slave bus
);

  localparam int unsigned      VEC_W = 4 * WIDTH;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(one_value(WIDTH, FIXED_POINT));
`ifdef MATVEC_AFFINE_EN
  localparam row_t LAST_ROW = 2'd2;
`else
  localparam row_t LAST_ROW = 2'd3;
`endif

  state_e state_q, state_d;
  row_t   cnt_q, cnt_d;
  logic   vin_ready_q, vin_ready_d;
  logic   busy_q, busy_d;
  logic   vout_valid_q, vout_valid_d;
  logic   accept_c;
  logic   issue_en_c;
  row_t   issue_row_c;

  logic [VEC_W-1:0] mat_q [NUM_ROWS];
  logic [WIDTH-1:0] result_q [NUM_ROWS];
  logic [VEC_W-1:0] row_data_c;
  logic [VEC_W-1:0] dp_x_q, dp_y_q;
  logic             dp_valid_q;
  row_t             dp_row_q;
  tag_t             tag_in, tag_out;

  // State and registered control outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vin_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      vout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vin_ready_q  <= vin_ready_d;
      busy_q       <= busy_d;
      vout_valid_q <= vout_valid_d;
    end
  end

  // Next state, row issue selection and next values of registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vout_valid_d = vout_valid_q;
    accept_c     = 1'b0;
    issue_en_c   = 1'b0;
    issue_row_c  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.vin_valid && vin_ready_q) begin
          accept_c    = 1'b1;
          issue_en_c  = 1'b1;
          issue_row_c = 2'd0;
          cnt_d       = 2'd1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue_en_c  = 1'b1;
        issue_row_c = cnt_q;
        cnt_d       = row_t'(cnt_q + 2'd1);
        if (cnt_q == LAST_ROW) state_d = DRAIN;
      end
      DRAIN: begin
        // Results return in issue order, so the last row closes the vertex.
        if (tag_out.valid && (tag_out.row == LAST_ROW)) begin
          state_d      = OUTPUT;
          vout_valid_d = 1'b1;
        end
      end
      OUTPUT: begin
        if (bus.vout_ready) begin
          state_d      = IDLE;
          vout_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    vin_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // A write landing on the same edge as the issue is forwarded to the operand.
  assign row_data_c = (bus.mat_wr_en && (bus.mat_wr_row == issue_row_c)) ? bus.mat_wr_data
                                                                         : mat_q[issue_row_c];

  // Matrix storage, identity after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < int'(NUM_ROWS); r++)
        for (int c = 0; c < int'(NUM_ROWS); c++)
          mat_q[r][c*WIDTH +: WIDTH] <= (r == c) ? ONE : '0;
    end else if (bus.mat_wr_en) begin
      mat_q[bus.mat_wr_row] <= bus.mat_wr_data;
    end
  end

  // Operand registers; values hold while no row is issued.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dp_valid_q <= 1'b0;
      dp_row_q   <= '0;
      dp_x_q     <= '0;
      dp_y_q     <= '0;
    end else begin
      dp_valid_q <= issue_en_c;
      if (issue_en_c) begin
        dp_x_q   <= row_data_c;
        dp_row_q <= issue_row_c;
      end
      if (accept_c) dp_y_q <= bus.vin_data;
    end
  end

  assign tag_in = '{valid: dp_valid_q, row: dp_row_q};

  issue_tag_pipe #(
    .DEPTH (DOT_LATENCY)
  ) u_tag_pipe (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tag_in   (tag_in),
    .tag_out  (tag_out)
  );

  // Result slots written by the emerging tag's row.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(NUM_ROWS); i++) result_q[i] <= '0;
    end else begin
`ifdef MATVEC_AFFINE_EN
      if (accept_c) result_q[3] <= ONE;
`endif
      if (tag_out.valid) result_q[tag_out.row] <= bus.dp_res_in;
    end
  end

  assign bus.vin_ready    = vin_ready_q;
  assign bus.busy         = busy_q;
  assign bus.vout_valid   = vout_valid_q;
  assign bus.vout_data    = {result_q[3], result_q[2], result_q[1], result_q[0]};
  assign bus.dp_valid_out = dp_valid_q;
  assign bus.dp_x_out     = dp_x_q;
  assign bus.dp_y_out     = dp_y_q;

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Directed bench for mat_vec_sequencer with a DOT_LATENCY-deep model dot stage.
module tb_mat_vec_sequencer;
  import mat_vec_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned L = 3;
`ifdef MATVEC_AFFINE_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_in = ~clk_in;

  mat_vec_sequencer_if #(.WIDTH(W)) bus ();

  mat_vec_sequencer #(
    .WIDTH       (W),
    .FIXED_POINT (FP),
    .DOT_LATENCY (L)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  // Model dot stage: four signed products, Q16.16 rescale in fixed-point builds.
  function automatic logic [W-1:0] dot(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
    longint acc = 0;
    for (int i = 0; i < 4; i++) begin
      longint p;
      p = longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]));
      acc += FP ? (p >>> (W / 2)) : p;
    end
    return W'(acc);
  endfunction

  logic [W-1:0] res_pipe [L];
  always @(posedge clk_in) begin
    res_pipe[0] <= dot(bus.dp_x_out, bus.dp_y_out);
    for (int i = 1; i < int'(L); i++) res_pipe[i] <= res_pipe[i-1];
  end
  assign bus.dp_res_in = res_pipe[L-1];

  function automatic logic [4*W-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {W'(e3), W'(e2), W'(e1), W'(e0)};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.vin_ready, bus.busy, bus.dp_valid_out, bus.vout_valid}, 0);
    check_eq({tag, "_vout_data"}, bus.vout_data, 0);
    check_eq({tag, "_dp_xy"}, bus.dp_x_out | bus.dp_y_out, 0);
  endtask

  task automatic write_row(input row_t r, input logic [4*W-1:0] d);
    bus.mat_wr_en   = 1'b1;
    bus.mat_wr_row  = r;
    bus.mat_wr_data = d;
    tick();
    bus.mat_wr_en   = 1'b0;
  endtask

  // Accept one vertex (optionally with a matrix write on the same edge) and
  // run until vout_valid; lat counts edges after the accepting edge.
  task automatic run_vertex(input logic [4*W-1:0] v, input bit wr, input row_t wr_row,
                            input logic [4*W-1:0] wr_data,
                            output int lat, output int nissue, output logic [4*W-1:0] res);
    int k = 0;
    while (!bus.vin_ready && k < 20) begin
      tick();
      k++;
    end
    check_eq("vin_ready_wait", bus.vin_ready, 1);
    bus.vin_valid   = 1'b1;
    bus.vin_data    = v;
    bus.mat_wr_en   = wr;
    bus.mat_wr_row  = wr_row;
    bus.mat_wr_data = wr_data;
    tick();
    bus.vin_valid = 1'b0;
    bus.mat_wr_en = 1'b0;
    lat    = 0;
    nissue = 0;
    while (!bus.vout_valid && lat < 40) begin
      if (bus.dp_valid_out) nissue++;
      tick();
      lat++;
    end
    res = bus.vout_data;
  endtask

  task automatic take_output(input string tag);
    bus.vout_ready = 1'b1;
    tick();
    bus.vout_ready = 1'b0;
    check_eq({tag, "_vin_ready_after"}, bus.vin_ready, 1);
    check_eq({tag, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    int lat, nissue, bad_data, bad_ready, bad_dp, bad_valid, seen_valid;
    logic [4*W-1:0] res;

    bus.mat_wr_en   = 1'b0;
    bus.mat_wr_row  = '0;
    bus.mat_wr_data = '0;
    bus.vin_valid   = 1'b0;
    bus.vin_data    = '0;
    bus.vout_ready  = 1'b0;
    rst_n_in        = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n_in = 1'b1;
    tick();
    check_eq("vin_ready_after_release", bus.vin_ready, 1);

`ifndef MATVEC_AFFINE_EN
    // Identity matrix passes the vertex through.
    run_vertex(pack4(1, 2, 3, 4), 1'b0, 2'd0, '0, lat, nissue, res);
    check_eq("t1_latency", lat, 7);
    check_eq("t1_issue_cycles", nissue, 4);
    check_eq("t1_vout", res, pack4(1, 2, 3, 4));
    take_output("t1");

    // Loaded matrix, all-ones vertex.
    write_row(2'd0, pack4(1, 0, 0, 5));
    write_row(2'd1, pack4(0, 2, 0, 0));
    write_row(2'd2, pack4(0, 0, 3, 0));
    write_row(2'd3, pack4(0, 0, 0, 1));
    run_vertex(pack4(1, 1, 1, 1), 1'b0, 2'd0, '0, lat, nissue, res);
    check_eq("t2_latency", lat, 7);
    check_eq("t2_issue_cycles", nissue, 4);
    check_eq("t2_vout", res, pack4(6, 2, 3, 1));

    // Backpressure: everything frozen in OUTPUT for 10 cycles.
    bad_data = 0; bad_ready = 0; bad_dp = 0; bad_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.vout_data !== pack4(6, 2, 3, 1)) bad_data++;
      if (bus.vin_ready !== 1'b0) bad_ready++;
      if (bus.dp_valid_out !== 1'b0) bad_dp++;
      if (bus.vout_valid !== 1'b1) bad_valid++;
    end
    check_eq("t3_data_unstable", bad_data, 0);
    check_eq("t3_vin_ready_high", bad_ready, 0);
    check_eq("t3_dp_valid_high", bad_dp, 0);
    check_eq("t3_vout_valid_dropped", bad_valid, 0);
    take_output("t3");

    // Row 0 written on the accepting edge must be used for that vertex.
    run_vertex(pack4(1, 2, 3, 4), 1'b1, 2'd0, pack4(0, 0, 0, 7), lat, nissue, res);
    check_eq("t4_latency", lat, 7);
    check_eq("t4_vout", res, pack4(28, 4, 9, 4));
    take_output("t4");

    // Asynchronous reset while draining.
    bus.vin_valid = 1'b1;
    bus.vin_data  = pack4(1, 2, 3, 4);
    tick();
    bus.vin_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t5_in_drain", {bus.busy, bus.dp_valid_out, bus.vout_valid}, 3'b100);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("t5_async_reset");
    tick();
    rst_n_in = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.vout_valid) seen_valid++;
    end
    check_eq("t5_no_vout_after_reset", seen_valid, 0);
    run_vertex(pack4(5, 6, 7, 8), 1'b0, 2'd0, '0, lat, nissue, res);
    check_eq("t5_latency", lat, 7);
    check_eq("t5_identity_restored", res, pack4(5, 6, 7, 8));
    take_output("t5");
`else
    // Affine, Q16.16: three rows issued, w forced to 1.0.
    run_vertex(pack4(32'h0002_0000, 32'h0003_0000, 32'h0000_8000, 32'h0005_0000),
               1'b0, 2'd0, '0, lat, nissue, res);
    check_eq("a1_latency", lat, 6);
    check_eq("a1_issue_cycles", nissue, 3);
    check_eq("a1_vout", res, pack4(32'h0002_0000, 32'h0003_0000, 32'h0000_8000, 32'h0001_0000));
    take_output("a1");

    run_vertex(pack4(32'h0001_0000, 0, 0, 32'h0002_0000), 1'b1, 2'd0,
               pack4(0, 0, 0, 32'h0007_0000), lat, nissue, res);
    check_eq("a2_latency", lat, 6);
    check_eq("a2_issue_cycles", nissue, 3);
    check_eq("a2_vout", res, pack4(32'h000E_0000, 0, 0, 32'h0001_0000));
    take_output("a2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_vec_sequencer.md
# mat_vec_sequencer

Sequences a 4x4 matrix by 4-vector transform through an external four-term dot-product stage. The block sits directly upstream of that stage in the vertex-transform path. It accepts one vertex per handshake, issues one matrix row per cycle as operands, realigns the returned scalars using a latency-matched tag pipe, and presents the assembled output vector on a valid/ready port. It also holds the transform matrix, which is loadable row by row.

## Interface
Parameters:
- WIDTH, 32, element width in bits (signed).
- FIXED_POINT, 0, 1 selects Q(WIDTH/2).(WIDTH/2) format for the constant ONE.
- DOT_LATENCY, 3, fixed cycles from operand issue to result on dp_res_in; must be ≥1.

Ports (vectors packed, element 0 in LSBs):
- clk_in  in  1  clock; all state on rising edge.
- rst_n_in  in  1  reset, asynchronous assert, active-low.
- mat_wr_en  in  1  write one matrix row.
- mat_wr_row  in  2  row index to write.
- mat_wr_data  in  4*WIDTH  row contents.
- vin_valid  in  1  input vertex valid.
- vin_ready  out  1  block can accept a vertex.
- vin_data  in  4*WIDTH  input vertex {w,z,y,x}.
- dp_x_out  out  4*WIDTH  matrix row operand.
- dp_y_out  out  4*WIDTH  vertex operand.
- dp_valid_out  out  1  operands valid this cycle.
- dp_res_in  in  WIDTH  dot-product result, DOT_LATENCY cycles after issue.
- vout_valid  out  1  output vector valid.
- vout_ready  in  1  consumer accepts.
- vout_data  out  4*WIDTH  transformed vertex.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on vin_valid && vin_ready. The vertex is latched.
  - ISSUE issues rows 0..3, one per cycle (dp_valid_out=1), with dp_y_out = the latched vertex. Goes to DRAIN after the last row.
  - DRAIN waits until every tagged result has been captured, then goes to OUTPUT.
  - OUTPUT holds vout_valid=1 and a stable vout_data until vout_ready. Goes to IDLE on the handshake.
- vin_ready = (state==IDLE). Only one vertex is in flight at a time.
- Tag pipe: a DOT_LATENCY-deep shift register of {valid,row}. When a tag emerges valid, dp_res_in is written to result slot [row].
- Matrix writes:
  - Accepted in any state and visible from the next cycle.
  - Rows already issued are unaffected.
  - If vin handshake and mat_wr_en occur in the same cycle, the write is visible to row issue, because row 0 issues the next cycle.
- Matrix reset value is identity: diagonal = ONE, other elements = 0. ONE = FIXED_POINT ? 1<<(WIDTH/2) : 1.
- No arithmetic is performed in this block; widths pass through unchanged.
- When dp_valid_out=0, dp_x_out and dp_y_out hold their last values.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE; tag pipe and results cleared; matrix set to identity.
  - All outputs are 0, including vin_ready, while rst_n_in is low. vin_ready=1 from the first edge after release.
  - Any in-flight vertex is discarded.
- Vertex accepted at edge T:
  - Row k issues in cycle T+1+k.
  - Its result is sampled at edge T+1+k+DOT_LATENCY.
  - vout_valid rises in cycle T+5+DOT_LATENCY (T+8 at default latency).
- vout handshake in cycle U: state is IDLE and vin_ready=1 in cycle U+1.
- Minimum period per vertex is 6+DOT_LATENCY cycles with vout_ready held high.
- Backpressure (vout_ready low) stalls only in OUTPUT. No further issue occurs, so no result can be lost.

## Configuration
- MATVEC_AFFINE_EN:
  - Defined: row 3 is never issued. ISSUE lasts 3 cycles; vout_data.w = ONE; vout_valid rises at T+4+DOT_LATENCY. Matrix row 3 is still writable but unused.
  - Undefined: full 4-row behaviour as above.

## Structure
- Package mat_vec_pkg holds:
  - the state enum {IDLE, ISSUE, DRAIN, OUTPUT};
  - the 2-bit row-index typedef;
  - a function returning ONE for a given WIDTH and FIXED_POINT.
- Sub-module issue_tag_pipe: the DOT_LATENCY-deep {valid,row} shift register, with asynchronous active-low reset.

## Test plan
- Reset, then vertex {1,2,3,4} with identity matrix and a model dot stage of DOT_LATENCY=3 → vout_data={1,2,3,4}, vout_valid at T+8.
- Write rows [[1,0,0,5],[0,2,0,0],[0,0,3,0],[0,0,0,1]] (integer), then vertex x=1,y=1,z=1,w=1 → out {6,2,3,1}; dp_valid_out high for exactly 4 cycles.
- Hold vout_ready=0 for 10 cycles → vout_data stable, vin_ready=0, no dp_valid_out. Release → vin_ready=1 in the next cycle.
- Same-cycle vertex accept and write of row 0 = [0,0,0,7] → output x=7·w.
- Assert rst_n_in mid-DRAIN → outputs immediately 0, no vout_valid afterwards, and the matrix is back to identity.
- With MATVEC_AFFINE_EN and FIXED_POINT=1, WIDTH=32 → 3 issue cycles; vout_data.w=32'h0001_0000; vout_valid at T+7.
